vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameters: FB_PIXELS, default 307200, frame-buffer size in pixels (640x480); WFIFO_DEPTH, default 4, write-FIFO entries (power of 2).
REQ-002 SHALL have ports:
- iCLK  in  1  pixel clock; single clock domain.
- iRST  in  1  asynchronous, active-high reset.
- iDispReq  in  1  display pixel request (active-area strobe from the VGA timing controller).
- iDispAddr  in  22  display pixel address (Y*640+X).
- oRed, oGreen, oBlue  out  8 each  pixel colour to the VGA DAC.
- oPixValid  out  1  colour outputs carry fetched data.
- iWrValid  in  1  host write request.
- iWrAddr  in  22  host write pixel address.
- iWrData  in  24  host write colour {R,G,B}.
- oWrReady  out  1  write FIFO can accept.
- oWrLevel  out  3  write-FIFO occupancy.
- oDropCnt  out  16  saturating count of dropped out-of-range writes.
- oMemAddr  out  19  frame-buffer RAM address.
- oMemWe  out  1  RAM write enable.
- oMemRe  out  1  RAM read enable.
- oMemWdata  out  24  RAM write data.
- iMemRdata  in  24  RAM read data; valid 1 cycle after a read-enabled cycle.

Function
REQ-003 SHALL arbitrate the single-port RAM each cycle between display reads and FIFO writes; display has strict priority.
REQ-004 SHALL run the FSM states IDLE, RD, WR, registered once per cycle from the sampled inputs.
- iDispReq=1 -> RD.
- else FIFO non-empty -> WR.
- else IDLE.
REQ-005 In RD, SHALL drive oMemRe=1, oMemWe=0, oMemAddr=iDispAddr[18:0] of the previous cycle.
REQ-006 In WR, SHALL drive oMemWe=1, oMemRe=0, oMemAddr/oMemWdata from the FIFO head, and pop exactly one entry.
REQ-007 In IDLE, SHALL drive oMemWe=0 and oMemRe=0; oMemAddr holds its last value.
REQ-008 Display latency SHALL be exactly 3 cycles:
- iDispReq sampled at N;
- RAM read at N+1;
- iMemRdata at N+2;
- oRed/oGreen/oBlue/oPixValid registered at N+3.
REQ-009 For cycles whose request was iDispReq=0, SHALL present oRed/oGreen/oBlue=0 and oPixValid=0 at the corresponding N+3 cycle (blanking).
REQ-010 oWrReady SHALL equal (FIFO count < WFIFO_DEPTH); a write is accepted when iWrValid && oWrReady at a rising edge.
REQ-011 SHALL drop any accepted write with iWrAddr >= FB_PIXELS before it enters the FIFO:
- no RAM access;
- oDropCnt increments, saturating at 16'hFFFF.
REQ-012 SHALL update occupancy correctly on a same-cycle push and pop: count unchanged, FIFO order preserved.
REQ-013 A full FIFO SHALL keep oWrReady=0 and ignore iWrValid; no overwrite.
REQ-014 SHALL service writes in FIFO order; no write is lost or duplicated.
REQ-015 When iDispReq is continuous, writes SHALL wait; they drain only in blanking cycles.
REQ-016 iDispAddr >= FB_PIXELS SHALL still read RAM at address iDispAddr[18:0]; there is no range check on reads.
REQ-017 oWrLevel SHALL equal the current FIFO count, 0..WFIFO_DEPTH.

Reset
REQ-018 While iRST=1, asynchronously:
- FSM=IDLE; FIFO empty; oWrLevel=0; oDropCnt=0;
- oMemWe=0, oMemRe=0, oMemAddr=0, oMemWdata=0;
- oRed/oGreen/oBlue=0, oPixValid=0;
- display pipeline cleared.
REQ-019 Reset asserted mid-operation SHALL discard pending FIFO entries and in-flight reads; no RAM write occurs during or in the first cycle after reset.
REQ-020 While iRST=1, oWrReady SHALL be 0; it becomes 1 from the first cycle after deassertion.

Verification
REQ-021 iDispReq=1, iDispAddr=100 at cycle 10; RAM model returns 24'hFF8000 -> oMemRe=1 and oMemAddr=100 at cycle 11; oRed=FF, oGreen=80, oBlue=00, oPixValid=1 at cycle 13.
REQ-022 iDispReq held at 1 for 640 cycles while 4 writes are pushed -> oWrReady=0 after 4 accepts, oMemWe=0 throughout; the 4 writes appear on oMemWe in order in the first 4 cycles after iDispReq falls.
REQ-023 Write iWrAddr=307200 accepted -> no oMemWe, oDropCnt=1, oWrLevel unchanged; 65536 such writes -> oDropCnt stays 16'hFFFF.
REQ-024 FIFO at count 2 with simultaneous push and WR pop -> oWrLevel stays 2; the popped entry is the oldest.
REQ-025 iRST pulsed with 3 entries queued and reads in flight -> oWrLevel=0, oPixValid=0, no oMemWe pulses afterward until a new write is accepted.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads have strict priority,
// host writes queue in a small FIFO and drain only in blanking cycles.
module vga_fb_arbiter #(
    parameter int unsigned FB_PIXELS   = 307200,
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDispReq,
    input  logic [21:0] iDispAddr,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue,
    output logic        oPixValid,
    input  logic        iWrValid,
    input  logic [21:0] iWrAddr,
    input  logic [23:0] iWrData,
    output logic        oWrReady,
    output logic [2:0]  oWrLevel,
    output logic [15:0] oDropCnt,
    output logic [18:0] oMemAddr,
    output logic        oMemWe,
    output logic        oMemRe,
    output logic [23:0] oMemWdata,
    input  logic [23:0] iMemRdata
);
    localparam int unsigned PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state;
    logic [18:0]       fifoAddr [WFIFO_DEPTH];
    logic [23:0]       fifoData [WFIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  countNext;
    logic              rdPipe;
    logic              accept;
    logic              inRange;
    logic              doPush;
    logic              doDrop;
    logic              doPop;
    logic              unusedDispHi;

    // Reads have no range check, so the upper display address bits are ignored.
    assign unusedDispHi = ^iDispAddr[21:19];

    assign accept  = iWrValid && oWrReady;
    assign inRange = 32'(iWrAddr) < FB_PIXELS;
    assign doPush  = accept && inRange;
    assign doDrop  = accept && !inRange;
    assign doPop   = !iDispReq && (count != '0);
    assign oWrLevel = 3'(count);

    always_comb begin
        countNext = count;
        if (doPush && !doPop)
            countNext = count + CNT_W'(1);
        else if (!doPush && doPop)
            countNext = count - CNT_W'(1);
    end

    // FIFO payload storage; validity is tracked by the pointers and count.
    always_ff @(posedge iCLK) begin
        if (doPush) begin
            fifoAddr[wrPtr] <= iWrAddr[18:0];
            fifoData[wrPtr] <= iWrData;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= IDLE;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            oWrReady  <= 1'b0;
            oDropCnt  <= 16'd0;
            oMemWe    <= 1'b0;
            oMemRe    <= 1'b0;
            oMemAddr  <= 19'd0;
            oMemWdata <= 24'd0;
            rdPipe    <= 1'b0;
            oRed      <= 8'd0;
            oGreen    <= 8'd0;
            oBlue     <= 8'd0;
            oPixValid <= 1'b0;
        end else begin
            // rdPipe marks the cycle in which iMemRdata answers a display read.
            rdPipe    <= (state == RD);
            oPixValid <= rdPipe;
            oRed      <= rdPipe ? iMemRdata[23:16] : 8'd0;
            oGreen    <= rdPipe ? iMemRdata[15:8]  : 8'd0;
            oBlue     <= rdPipe ? iMemRdata[7:0]   : 8'd0;

            count    <= countNext;
            oWrReady <= 32'(countNext) < WFIFO_DEPTH;
            if (doPush)
                wrPtr <= wrPtr + PTR_W'(1);
            if (doDrop && (oDropCnt != 16'hFFFF))
                oDropCnt <= oDropCnt + 16'd1;

            if (iDispReq) begin
                state    <= RD;
                oMemRe   <= 1'b1;
                oMemWe   <= 1'b0;
                oMemAddr <= iDispAddr[18:0];
            end else if (doPop) begin
                state     <= WR;
                oMemRe    <= 1'b0;
                oMemWe    <= 1'b1;
                oMemAddr  <= fifoAddr[rdPtr];
                oMemWdata <= fifoData[rdPtr];
                rdPtr     <= rdPtr + PTR_W'(1);
            end else begin
                state  <= IDLE;
                oMemRe <= 1'b0;
                oMemWe <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: behavioural queue model of the
// write FIFO and display pipeline, plus a synchronous RAM model.
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        iRST;
    logic        iDispReq;
    logic [21:0] iDispAddr;
    logic [7:0]  oRed, oGreen, oBlue;
    logic        oPixValid;
    logic        iWrValid;
    logic [21:0] iWrAddr;
    logic [23:0] iWrData;
    logic        oWrReady;
    logic [2:0]  oWrLevel;
    logic [15:0] oDropCnt;
    logic [18:0] oMemAddr;
    logic        oMemWe, oMemRe;
    logic [23:0] oMemWdata;
    logic [23:0] memRdata;

    int checks = 0;
    int failures = 0;

    vga_fb_arbiter dut (
        .iCLK(clk), .iRST(iRST),
        .iDispReq(iDispReq), .iDispAddr(iDispAddr),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oPixValid(oPixValid),
        .iWrValid(iWrValid), .iWrAddr(iWrAddr), .iWrData(iWrData),
        .oWrReady(oWrReady), .oWrLevel(oWrLevel), .oDropCnt(oDropCnt),
        .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemRe(oMemRe),
        .oMemWdata(oMemWdata), .iMemRdata(memRdata)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten locations return a fixed address-derived pattern.
    logic [23:0] mem [int unsigned];

    function automatic logic [23:0] rd(input logic [18:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return (24'(a) * 24'd40503) ^ 24'hC3A55A;
    endfunction

    always @(posedge clk) begin
        if (oMemRe) memRdata <= rd(oMemAddr);
        if (oMemWe) mem[32'(oMemAddr)] = oMemWdata;
    end

    // Reference model state
    logic [42:0] wq [$];
    logic [24:0] pixQ [$];
    logic        expWe, expRe, mReady;
    logic [18:0] expAddr;
    logic [23:0] expWdata;
    logic [24:0] expPix;
    logic [15:0] mDrop;

    task automatic modelReset();
        wq.delete();
        pixQ.delete();
        pixQ.push_back(25'd0);
        pixQ.push_back(25'd0);
        expWe = 0; expRe = 0; mReady = 0;
        expAddr = '0; expWdata = '0; expPix = '0; mDrop = '0;
    endtask

    // Advance the model by one edge from the current inputs, then clock the DUT.
    task automatic tick();
        logic [42:0] ent;
        pixQ.push_back(iDispReq ? {1'b1, rd(iDispAddr[18:0])} : 25'd0);
        expPix = pixQ.pop_front();
        expWe = 0;
        expRe = 0;
        if (iDispReq) begin
            expRe = 1;
            expAddr = iDispAddr[18:0];
        end else if (wq.size() > 0) begin
            ent = wq.pop_front();
            expWe = 1;
            expAddr = ent[42:24];
            expWdata = ent[23:0];
        end
        if (iWrValid && mReady) begin
            if (32'(iWrAddr) < 307200) wq.push_back({iWrAddr[18:0], iWrData});
            else if (mDrop != 16'hFFFF) mDrop++;
        end
        mReady = wq.size() < 4;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] readAddr();
        logic [2:0] hi;
        hi = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        return {hi, 1'b0, 18'($urandom)};
    endfunction

    task automatic idleInputs();
        iDispReq = 0; iDispAddr = '0; iWrValid = 0; iWrAddr = '0; iWrData = '0;
    endtask

    task automatic test_reset();
        iRST = 1;
        idleInputs();
        modelReset();
        #3;
        if ({oMemWe, oMemRe, oMemAddr, oMemWdata} !== 45'd0) begin
            failures++; $display("FAIL reset_mem got we=%b re=%b addr=%h wd=%h exp all 0", oMemWe, oMemRe, oMemAddr, oMemWdata);
        end
        checks++;
        if ({oPixValid, oRed, oGreen, oBlue, oWrReady, oWrLevel, oDropCnt} !== 45'd0) begin
            failures++; $display("FAIL reset_out got pv=%b rgb=%h%h%h rdy=%b lvl=%0d drop=%0d exp all 0",
                                 oPixValid, oRed, oGreen, oBlue, oWrReady, oWrLevel, oDropCnt);
        end
        checks++;
        @(posedge clk); #1;
        iRST = 0;
        if (oWrReady !== 1'b0) begin failures++; $display("FAIL reset_rdy0 got=%b exp=0", oWrReady); end
        checks++;
        tick();
        if (oWrReady !== 1'b1 || oWrLevel !== 3'd0) begin
            failures++; $display("FAIL reset_rdy1 got rdy=%b lvl=%0d exp rdy=1 lvl=0", oWrReady, oWrLevel);
        end
        checks++;
    endtask

    task automatic test_single_read();
        mem[100] = 24'hFF8000;
        iDispReq = 1; iDispAddr = 22'd100;
        tick();
        iDispReq = 0;
        if (oMemRe !== 1'b1 || oMemAddr !== 19'd100) begin
            failures++; $display("FAIL read_issue got re=%b addr=%0d exp re=1 addr=100", oMemRe, oMemAddr);
        end
        checks++;
        tick();
        if (oPixValid !== 1'b0) begin failures++; $display("FAIL read_early got pv=%b exp=0", oPixValid); end
        checks++;
        tick();
        if ({oPixValid, oRed, oGreen, oBlue} !== {1'b1, 24'hFF8000}) begin
            failures++; $display("FAIL read_pixel got pv=%b rgb=%h%h%h exp pv=1 rgb=ff8000", oPixValid, oRed, oGreen, oBlue);
        end
        checks++;
        tick();
        if ({oPixValid, oRed, oGreen, oBlue} !== 25'd0) begin
            failures++; $display("FAIL read_blank got pv=%b rgb=%h%h%h exp 0", oPixValid, oRed, oGreen, oBlue);
        end
        checks++;
    endtask

    task automatic test_disp_priority();
        logic [18:0] pa [4];
        logic [23:0] pd [4];
        int accepts = 0;
        for (int i = 0; i < 4; i++) begin
            pa[i] = 19'(270000 + i * 13);
            pd[i] = 24'($urandom);
        end
        iDispReq = 1;
        for (int c = 0; c < 640; c++) begin
            iDispAddr = readAddr();
            iWrValid = (c < 10);
            iWrAddr = (c < 4) ? 22'(pa[c]) : 22'd300000;
            iWrData = (c < 4) ? pd[c] : 24'hDEAD00;
            if (iWrValid && oWrReady) accepts++;
            tick();
            if (oMemWe !== 1'b0) begin failures++; $display("FAIL prio_we cyc=%0d got=%b exp=0", c, oMemWe); end
            checks++;
            if (accepts >= 4 && oWrReady !== 1'b0) begin
                failures++; $display("FAIL prio_full cyc=%0d got rdy=%b exp=0", c, oWrReady);
            end
            if (accepts >= 4) checks++;
        end
        iDispReq = 0; iWrValid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (oMemWe !== 1'b1 || oMemAddr !== pa[i] || oMemWdata !== pd[i]) begin
                failures++; $display("FAIL prio_drain%0d got we=%b addr=%0d wd=%h exp we=1 addr=%0d wd=%h",
                                     i, oMemWe, oMemAddr, oMemWdata, pa[i], pd[i]);
            end
            checks++;
        end
        tick();
        if (oMemWe !== 1'b0 || oWrLevel !== 3'd0) begin
            failures++; $display("FAIL prio_empty got we=%b lvl=%0d exp we=0 lvl=0", oMemWe, oWrLevel);
        end
        checks++;
    endtask

    task automatic test_push_pop();
        iDispReq = 1; iDispAddr = 22'd5; iWrValid = 1;
        iWrAddr = 22'd280001; iWrData = 24'h111111; tick();
        iWrAddr = 22'd280002; iWrData = 24'h222222; tick();
        iDispReq = 0;
        iWrAddr = 22'd280003; iWrData = 24'h333333; tick();
        iWrValid = 0;
        if (oWrLevel !== 3'd2 || oMemWe !== 1'b1 || oMemAddr !== 19'd280001 || oMemWdata !== 24'h111111) begin
            failures++; $display("FAIL pushpop got lvl=%0d we=%b addr=%0d wd=%h exp lvl=2 we=1 addr=280001 wd=111111",
                                 oWrLevel, oMemWe, oMemAddr, oMemWdata);
        end
        checks++;
        tick(); tick();
        if (oMemAddr !== 19'd280003 || oWrLevel !== 3'd0) begin
            failures++; $display("FAIL pushpop_tail got addr=%0d lvl=%0d exp addr=280003 lvl=0", oMemAddr, oWrLevel);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            iDispReq = ($urandom_range(0, 99) < 60);
            iDispAddr = readAddr();
            iWrValid = $urandom_range(0, 1) == 1;
            iWrAddr = ($urandom_range(0, 4) != 0) ? 22'($urandom_range(262144, 307199))
                                                  : 22'($urandom_range(307200, 4194303));
            iWrData = 24'($urandom);
            tick();
            if (oMemRe !== expRe || oMemWe !== expWe) begin
                failures++; $display("FAIL rand_ctl cyc=%0d got re=%b we=%b exp re=%b we=%b", c, oMemRe, oMemWe, expRe, expWe);
            end
            checks++;
            if (oMemAddr !== expAddr || oMemWdata !== expWdata) begin
                failures++; $display("FAIL rand_bus cyc=%0d got addr=%h wd=%h exp addr=%h wd=%h", c, oMemAddr, oMemWdata, expAddr, expWdata);
            end
            checks++;
            if ({oPixValid, oRed, oGreen, oBlue} !== expPix) begin
                failures++; $display("FAIL rand_pix cyc=%0d got=%h exp=%h", c, {oPixValid, oRed, oGreen, oBlue}, expPix);
            end
            checks++;
            if (oWrLevel !== 3'(wq.size()) || oWrReady !== mReady || oDropCnt !== mDrop) begin
                failures++; $display("FAIL rand_fifo cyc=%0d got lvl=%0d rdy=%b drop=%0d exp lvl=%0d rdy=%b drop=%0d",
                                     c, oWrLevel, oWrReady, oDropCnt, wq.size(), mReady, mDrop);
            end
            checks++;
        end
        idleInputs();
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset_mid();
        iDispReq = 1; iWrValid = 1;
        for (int i = 0; i < 3; i++) begin
            iDispAddr = readAddr();
            iWrAddr = 22'(290000 + i); iWrData = 24'(i + 1);
            tick();
        end
        if (oWrLevel !== 3'd3) begin failures++; $display("FAIL rstmid_pre got lvl=%0d exp=3", oWrLevel); end
        checks++;
        #2 iRST = 1;
        #1;
        if (oWrLevel !== 3'd0 || oPixValid !== 1'b0 || oMemWe !== 1'b0 || oWrReady !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got lvl=%0d pv=%b we=%b rdy=%b exp 0", oWrLevel, oPixValid, oMemWe, oWrReady);
        end
        checks++;
        idleInputs();
        modelReset();
        @(posedge clk); #1;
        iRST = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (oMemWe !== 1'b0 || oPixValid !== 1'b0 || oWrLevel !== 3'd0) begin
                failures++; $display("FAIL rstmid_post cyc=%0d got we=%b pv=%b lvl=%0d exp 0", i, oMemWe, oPixValid, oWrLevel);
            end
            checks++;
        end
        iWrValid = 1; iWrAddr = 22'd295000; iWrData = 24'hABCDEF; tick();
        iWrValid = 0; tick();
        if (oMemWe !== 1'b1 || oMemAddr !== 19'd295000 || oMemWdata !== 24'hABCDEF) begin
            failures++; $display("FAIL rstmid_new got we=%b addr=%0d wd=%h exp we=1 addr=295000 wd=abcdef", oMemWe, oMemAddr, oMemWdata);
        end
        checks++;
    endtask

    task automatic test_drop();
        iWrValid = 1; iWrAddr = 22'd307200; iWrData = 24'h123456;
        tick();
        iWrValid = 0;
        tick();
        if (oDropCnt !== 16'd1 || oWrLevel !== 3'd0 || oMemWe !== 1'b0) begin
            failures++; $display("FAIL drop_one got drop=%0d lvl=%0d we=%b exp drop=1 lvl=0 we=0", oDropCnt, oWrLevel, oMemWe);
        end
        checks++;
        iWrValid = 1;
        for (int i = 0; i < 65536; i++) begin
            iWrAddr = 22'($urandom_range(307200, 4194303));
            tick();
            if (oMemWe !== 1'b0) begin failures++; $display("FAIL drop_we i=%0d got=%b exp=0", i, oMemWe); end
            if (i % 4096 == 0) checks++;
        end
        iWrValid = 0;
        tick();
        if (oDropCnt !== 16'hFFFF || mDrop !== 16'hFFFF) begin
            failures++; $display("FAIL drop_sat got=%h exp=ffff", oDropCnt);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_disp_priority();
        test_push_pop();
        test_random();
        test_reset_mid();
        test_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
